// File: rtl/display_scheduler.sv
// Four-digit multiplexed 7-segment display scheduler with a shadow/active digit
// buffer pair; shadow contents are committed to the display only at frame boundaries.
module display_scheduler #(
  parameter int CLK_DIVIDE   = 12000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       wr_dp,
  input  logic       commit,
  output logic       commit_pending,
  input  logic [3:0] digit_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int               CNT_W     = $clog2(CLK_DIVIDE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIVIDE - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_SHOW} slot_state_e;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
  } digit_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    hex7 = 7'h00;
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  slot_state_e      state_q, state_d;
  digit_t [3:0]     shadow_q, shadow_d;
  digit_t [3:0]     active_q, active_d;
  logic             pending_q, pending_d;
  logic             ready_en_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fs_q, fs_d;

  logic boundary, do_copy, wr_fire;

  // The copy is decided in the boundary cycle itself, so a commit arriving exactly then still lands.
  assign boundary = (cnt_q == CNT_LAST) && (idx_q == 2'd3);
  assign do_copy  = boundary && (pending_q || commit);
  assign wr_ready = ready_en_q && !do_copy;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    // NOTE: every _d is given a default before any branch, so no path can infer a latch.
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d     = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
    state_d   = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q || commit;
    an_d      = 4'hF;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    fs_d      = (cnt_q == '0) && (idx_q == 2'd0);

    if (wr_fire) begin
      shadow_d[wr_digit] = '{value: wr_value, dp: wr_dp};
    end
    if (do_copy) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (state_q == ST_SHOW) begin
      an_d  = digit_en[idx_q] ? ~(4'b0001 << idx_q) : 4'hF;
      seg_d = ~hex7(active_q[idx_q].value);
      dp_d  = ~active_q[idx_q].dp;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      // NOTE: the digit buffers are only a few flops and a mid-frame reset must discard them, so they are reset.
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      state_q    <= ST_BLANK;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      ready_en_q <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      ready_en_q <= 1'b1;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign commit_pending = pending_q;
  assign an             = an_q;
  assign seg            = seg_q;
  assign dp             = dp_q;
  assign frame_start    = fs_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: a cycle model pushes expected outputs to a
// scoreboard queue every edge, plus directed checks of timing, commit and reset behaviour.
module tb_display_scheduler;

  localparam int CLK_DIVIDE   = 10;
  localparam int BLANK_CYCLES = 2;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [3:0] wr_value;
  logic       wr_dp;
  logic       commit;
  logic       commit_pending;
  logic [3:0] digit_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  display_scheduler #(
    .CLK_DIVIDE  (CLK_DIVIDE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_digit      (wr_digit),
    .wr_value      (wr_value),
    .wr_dp         (wr_dp),
    .commit        (commit),
    .commit_pending(commit_pending),
    .digit_en      (digit_en),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .frame_start   (frame_start)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  localparam obs_t RST_OBS = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] segn(input logic [3:0] v);
    return ~hex_tbl[v];
  endfunction

  function automatic logic [3:0] an_on(input int k);
    logic [3:0] a;
    a = 4'b0001 << k;
    return ~a;
  endfunction

  // Reference model: plain counters and arrays, updated once per rising edge.
  int         m_cnt, m_idx;
  logic [4:0] m_shadow [4];
  logic [4:0] m_active [4];
  logic       m_pending, m_alive;
  logic       m_bnd, m_copy;

  assign m_bnd  = (m_cnt == CLK_DIVIDE - 1) && (m_idx == 3);
  assign m_copy = m_bnd && (m_pending || commit);

  function automatic obs_t model_out();
    obs_t o;
    o.fs  = (m_cnt == 0) && (m_idx == 0);
    o.an  = 4'hF;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    if (m_cnt >= BLANK_CYCLES) begin
      o.an  = digit_en[m_idx] ? an_on(m_idx) : 4'hF;
      o.seg = segn(m_active[m_idx][4:1]);
      o.dp  = ~m_active[m_idx][0];
    end
    return o;
  endfunction

  always @(posedge sysclk) begin
    if (reset) begin
      exp_q.push_back(RST_OBS);
      m_cnt     <= 0;
      m_idx     <= 0;
      m_pending <= 1'b0;
      m_alive   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] <= '0;
        m_active[i] <= '0;
      end
    end else begin
      exp_q.push_back(model_out());
      if (wr_valid && m_alive && !m_copy) m_shadow[wr_digit] <= {wr_value, wr_dp};
      if (m_copy) begin
        for (int i = 0; i < 4; i++) m_active[i] <= m_shadow[i];
        m_pending <= 1'b0;
      end else if (commit) begin
        m_pending <= 1'b1;
      end
      m_cnt <= (m_cnt == CLK_DIVIDE - 1) ? 0 : m_cnt + 1;
      if (m_cnt == CLK_DIVIDE - 1) m_idx <= (m_idx + 1) % 4;
      m_alive <= 1'b1;
    end
  end

  // Scoreboard monitor: registered outputs at +1, handshake/status at +7 once inputs are settled.
  always begin : monitor
    obs_t e;
    @(posedge sysclk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_an", an, e.an);
      check("sb_seg", seg, e.seg);
      check("sb_dp", dp, e.dp);
      check("sb_frame_start", frame_start, e.fs);
    end
    #6;
    check("sb_wr_ready", wr_ready, m_alive && !m_copy);
    check("sb_commit_pending", commit_pending, m_pending);
  end

  task automatic cycle();
    @(posedge sysclk);
    #2;
    cyc++;
  endtask

  // Advance at least one cycle, stopping when the frame phase (cyc mod 40) matches.
  task automatic run_to(input int phase);
    cycle();
    for (int k = 0; k < 40 && (cyc % 40) != phase; k++) cycle();
  endtask

  task automatic write_digit(input logic [1:0] d, input logic [3:0] v, input logic p);
    logic acc;
    acc      = 1'b0;
    wr_valid = 1'b1;
    wr_digit = d;
    wr_value = v;
    wr_dp    = p;
    for (int k = 0; k < 4 && !acc; k++) begin
      #1;
      acc = wr_ready;
      cycle();
    end
    wr_valid = 1'b0;
    check("wr_accept", acc, 1);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
  endtask

  task automatic slot_check(input string tag, input int phase, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
    run_to(phase);
    check({tag, "_an"}, an, an_e);
    check({tag, "_seg"}, seg, seg_e);
    check({tag, "_dp"}, dp, dp_e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_pending"}, commit_pending, 0);
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pos, id;
    logic [3:0] an_e;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_digit = 2'd0;
    wr_value = 4'd0;
    wr_dp    = 1'b0;
    commit   = 1'b0;
    digit_en = 4'hF;

    repeat (3) cycle();
    check_reset_outputs("rst");
    reset = 1'b0;
    cyc   = 0;

    // Reset release timing over one full frame plus the next frame start.
    for (int c = 1; c <= 41; c++) begin
      cycle();
      pos  = (c - 1) % 10;
      id   = ((c - 1) / 10) % 4;
      an_e = (pos < 2) ? 4'hF : an_on(id);
      check("rel_fs", frame_start, (c == 1 || c == 41));
      check("rel_an", an, an_e);
      if (pos >= 2) check("rel_seg", seg, segn(4'h0));
    end

    // Writes stay in shadow until the commit is applied at the frame boundary.
    write_digit(2'd0, 4'h1, 1'b0);
    write_digit(2'd1, 4'h2, 1'b0);
    write_digit(2'd2, 4'h3, 1'b1);
    write_digit(2'd3, 4'h4, 1'b0);
    pulse_commit();
    check("wr_pending_set", commit_pending, 1);
    slot_check("wr_hidden", 35, an_on(3), segn(4'h0), 1'b1);
    slot_check("wr_d0", 5, an_on(0), segn(4'h1), 1'b1);
    slot_check("wr_d1", 15, an_on(1), segn(4'h2), 1'b1);
    slot_check("wr_d2", 25, an_on(2), segn(4'h3), 1'b0);
    slot_check("wr_d3", 35, an_on(3), segn(4'h4), 1'b1);
    check("wr_pending_clr", commit_pending, 0);

    // Commit raised exactly in the boundary cycle.
    write_digit(2'd0, 4'hA, 1'b0);
    write_digit(2'd1, 4'hB, 1'b0);
    write_digit(2'd2, 4'hC, 1'b0);
    write_digit(2'd3, 4'hD, 1'b0);
    run_to(39);
    commit = 1'b1;
    #1;
    check("bnd_ready_low", wr_ready, 0);
    check("bnd_pending_low", commit_pending, 0);
    cycle();
    commit = 1'b0;
    #1;
    check("bnd_ready_back", wr_ready, 1);
    check("bnd_pending_after", commit_pending, 0);
    slot_check("bnd_d0", 5, an_on(0), segn(4'hA), 1'b1);
    slot_check("bnd_d1", 15, an_on(1), segn(4'hB), 1'b1);

    // A write held across a boundary copy stalls one cycle and lands in shadow only.
    write_digit(2'd0, 4'h5, 1'b0);
    run_to(20);
    pulse_commit();
    check("stall_pending", commit_pending, 1);
    run_to(39);
    wr_valid = 1'b1;
    wr_digit = 2'd1;
    wr_value = 4'h7;
    wr_dp    = 1'b0;
    #1;
    check("stall_ready_low", wr_ready, 0);
    cycle();
    #1;
    check("stall_ready_high", wr_ready, 1);
    cycle();
    wr_valid = 1'b0;
    slot_check("stall_d0", 5, an_on(0), segn(4'h5), 1'b1);
    slot_check("stall_d1_old", 15, an_on(1), segn(4'hB), 1'b1);
    slot_check("stall_d1_still", 15, an_on(1), segn(4'hB), 1'b1);
    pulse_commit();
    slot_check("stall_d1_new", 15, an_on(1), segn(4'h7), 1'b1);

    // Digit enables mask the anodes of disabled slots only.
    digit_en = 4'b0101;
    slot_check("en_d0", 5, an_on(0), segn(4'h5), 1'b1);
    slot_check("en_d1", 15, 4'hF, segn(4'h7), 1'b1);
    slot_check("en_d2", 25, an_on(2), segn(4'hC), 1'b1);
    slot_check("en_d3", 35, 4'hF, segn(4'hD), 1'b1);
    digit_en = 4'hF;

    // Reset mid-frame with a commit pending discards shadow, active and the commit.
    write_digit(2'd3, 4'h9, 1'b0);
    run_to(22);
    pulse_commit();
    run_to(25);
    check("mid_pending_before", commit_pending, 1);
    reset = 1'b1;
    cycle();
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    cyc   = 0;
    cycle();
    check("mid_first_fs", frame_start, 1);
    slot_check("mid_d3", 35, an_on(3), segn(4'h0), 1'b1);
    slot_check("mid_next_d0", 5, an_on(0), segn(4'h0), 1'b1);
    slot_check("mid_next_d3", 35, an_on(3), segn(4'h0), 1'b1);
    check("mid_pending_after", commit_pending, 0);

    cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
